// File: rtl/stopwatch_control_pkg.sv
// Shared definitions for the stopwatch controller: state encodings, seconds limit
// and field-select constants.
package stopwatch_control_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_PAUSED = 2'd1,
      ST_ADJUST = 2'd2
   } state_t;

   localparam int SECONDS_MAX = 59;

   localparam logic SEL_MINUTES = 1'b0;
   localparam logic SEL_SECONDS = 1'b1;

   function automatic logic [3:0] tens_of(input int value);
      return 4'(value / 10);
   endfunction

   function automatic logic [3:0] ones_of(input int value);
      return 4'(value % 10);
   endfunction

endpackage

// File: rtl/stopwatch_control_bcd2_counter.sv
// Two-digit BCD counter that wraps to 00 after the {max_tens,max_ones} limit;
// carry flags an increment that wrapped.
module bcd2_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic [3:0] max_tens,
   input  logic [3:0] max_ones,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       carry
);

   logic at_max;

   assign at_max = (tens == max_tens) && (ones == max_ones);
   assign carry  = inc && at_max;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tens <= 4'd0;
         ones <= 4'd0;
      end else if (inc) begin
         if (at_max) begin
            tens <= 4'd0;
            ones <= 4'd0;
         end else if (ones == 4'd9) begin
            tens <= tens + 4'd1;
            ones <= 4'd0;
         end else begin
            ones <= ones + 4'd1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch sequencing controller: RUN/PAUSED/ADJUST FSM driving two BCD counters.
// Define STOPWATCH_ROLLOVER_EN to wrap MINUTES_MAX:59 to 00:00 instead of saturating.
module stopwatch_control
   import stopwatch_control_pkg::*;
#(
   parameter int MINUTES_MAX = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   input  logic       pause_pulse,
   input  logic       sw_adj,
   input  logic       sw_sel,
   output logic [3:0] minutes_tens,
   output logic [3:0] minutes_ones,
   output logic [3:0] seconds_tens,
   output logic [3:0] seconds_ones,
   output logic       adj,
   output logic       sel,
   output logic       running
);

   localparam logic [3:0] MIN_TENS = tens_of(MINUTES_MAX);
   localparam logic [3:0] MIN_ONES = ones_of(MINUTES_MAX);
   localparam logic [3:0] SEC_TENS = tens_of(SECONDS_MAX);
   localparam logic [3:0] SEC_ONES = ones_of(SECONDS_MAX);

   state_t state;
   logic   resume;
   logic   run_tick, count_tick, adj_tick, at_limit;
   logic   sec_inc, min_inc, sec_carry, min_carry;

   assign at_limit = (minutes_tens == MIN_TENS) && (minutes_ones == MIN_ONES) &&
                     (seconds_tens == SEC_TENS) && (seconds_ones == SEC_ONES);
   assign run_tick = (state == ST_RUN) && tick_1hz;
   assign adj_tick = (state == ST_ADJUST) && tick_2hz;

`ifdef STOPWATCH_ROLLOVER_EN
   assign count_tick = run_tick;
`else
   assign count_tick = run_tick && !at_limit;
`endif

   // Adjust selection uses the live switch so a select change and tick in one cycle hit the new field
   assign sec_inc = count_tick || (adj_tick && (sw_sel == SEL_SECONDS));
   assign min_inc = (count_tick && sec_carry) || (adj_tick && (sw_sel == SEL_MINUTES));

   bcd2_counter u_seconds (
      .clk      (clk),
      .rst      (rst),
      .inc      (sec_inc),
      .max_tens (SEC_TENS),
      .max_ones (SEC_ONES),
      .tens     (seconds_tens),
      .ones     (seconds_ones),
      .carry    (sec_carry)
   );

   bcd2_counter u_minutes (
      .clk      (clk),
      .rst      (rst),
      .inc      (min_inc),
      .max_tens (MIN_TENS),
      .max_ones (MIN_ONES),
      .tens     (minutes_tens),
      .ones     (minutes_ones),
      .carry    (min_carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_RUN;
         resume  <= 1'b1;
         adj     <= 1'b0;
         sel     <= 1'b0;
         running <= 1'b1;
      end else begin
         sel <= sw_sel;
         case (state)
            ST_RUN: begin
               if (sw_adj) begin
                  state   <= ST_ADJUST;
                  resume  <= 1'b1;
                  adj     <= 1'b1;
                  running <= 1'b0;
               end else if (pause_pulse) begin
                  state   <= ST_PAUSED;
                  running <= 1'b0;
               end
            end
            ST_PAUSED: begin
               if (sw_adj) begin
                  state  <= ST_ADJUST;
                  resume <= 1'b0;
                  adj    <= 1'b1;
               end else if (pause_pulse) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
            end
            ST_ADJUST: begin
               // A pause pulse in the exit cycle still counts toward the return state
               resume <= resume ^ pause_pulse;
               if (!sw_adj) begin
                  state   <= (resume ^ pause_pulse) ? ST_RUN : ST_PAUSED;
                  adj     <= 1'b0;
                  running <= resume ^ pause_pulse;
               end
            end
            default: begin
               state   <= ST_RUN;
               resume  <= 1'b1;
               adj     <= 1'b0;
               running <= 1'b1;
            end
         endcase
      end
   end

endmodule
